// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM
// states, datapath select codes and the instruction classes seen by EXEC.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [1:0] PCS_PC4  = 2'd0;
  localparam logic [1:0] PCS_BR   = 2'd1;
  localparam logic [1:0] PCS_JMP  = 2'd2;
  localparam logic [1:0] PCS_RS   = 2'd3;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] ALU_IMM   = 2'd3;

  localparam logic [1:0] RD_RT    = 2'd0;
  localparam logic [1:0] RD_RD    = 2'd1;
  localparam logic [1:0] RD_RA    = 2'd2;

  localparam logic [1:0] M2R_ALU  = 2'd0;
  localparam logic [1:0] M2R_MEM  = 2'd1;
  localparam logic [1:0] M2R_PC4  = 2'd2;

  typedef enum logic [3:0] {
    CLS_R, CLS_JR, CLS_IALU, CLS_LW, CLS_SW,
    CLS_BEQ, CLS_BNE, CLS_J, CLS_JAL, CLS_ILL
  } instr_cls_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mips_mc_decode.sv
// Combinational instruction classifier: opcode/funct -> class + illegal flag.
module mips_mc_decode
  import mips_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  output instr_cls_e  cls_o,
  output logic        illegal_o
);

  // Map each opcode onto the EXEC behaviour it needs; anything unknown is illegal.
  always_comb begin
    cls_o = CLS_ILL;
    case (opcode_i)
      OP_RTYPE: cls_o = (funct_i == FN_JR) ? CLS_JR : CLS_R;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: cls_o = CLS_IALU;
      OP_LW:  cls_o = CLS_LW;
      OP_SW:  cls_o = CLS_SW;
      OP_BEQ: cls_o = CLS_BEQ;
      OP_BNE: cls_o = CLS_BNE;
      OP_J:   cls_o = CLS_J;
      OP_JAL: cls_o = CLS_JAL;
      default: cls_o = CLS_ILL;
    endcase
    illegal_o = (cls_o == CLS_ILL);
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB with parameterised
// memory wait states, stall freeze and a wrapping retired-instruction count.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int IMEM_LAT = 1,
  parameter int DMEM_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             stall,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             reg_we,
  output logic             CEN,
  output logic             WEN,
  output logic             OEN,
  output logic             illegal,
  output logic             retired,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int WAIT_W = $clog2(max2(IMEM_LAT, DMEM_LAT)) + 1;
  localparam logic [WAIT_W-1:0] ILAST = WAIT_W'(IMEM_LAT - 1);
  localparam logic [WAIT_W-1:0] DLAST = WAIT_W'(DMEM_LAT - 1);

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  instr_cls_e        cls_q, cls_d, dec_cls;
  logic              ill_q, ill_d, dec_ill;
  logic [CNT_W-1:0]  cnt_q;
  logic              fetch_last, mem_last, strobe_en;
  logic              ir_we_r, pc_we_r, reg_we_r, ret_r;

  mips_mc_decode u_decode (
    .opcode_i  (opcode),
    .funct_i   (funct),
    .cls_o     (dec_cls),
    .illegal_o (dec_ill)
  );

  assign fetch_last = (state_q == S_FETCH) && (wait_q == ILAST);
  assign mem_last   = (state_q == S_MEM)   && (wait_q == DLAST);
  // Reset and stall both suppress every one-cycle strobe.
  assign strobe_en  = !stall && !rst;

  // Next-state logic: wait-state counting in FETCH/MEM, class capture in DECODE.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cls_d   = cls_q;
    ill_d   = ill_q;
    case (state_q)
      S_FETCH: begin
        if (fetch_last) begin
          state_d = S_DECODE;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        cls_d   = dec_cls;
        ill_d   = dec_ill;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (cls_q)
          CLS_R, CLS_IALU: state_d = S_WB;
          CLS_LW, CLS_SW:  state_d = S_MEM;
          default:         state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_last) begin
          wait_d  = '0;
          state_d = (cls_q == CLS_LW) ? S_WB : S_FETCH;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State, wait counter and retire counter; all frozen while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cls_q   <= CLS_R;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (!stall) begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cls_q   <= cls_d;
      ill_q   <= ill_d;
      if (ret_r) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Output decode of the current state; selects hold for the whole state.
  always_comb begin
    ir_we_r    = 1'b0;
    pc_we_r    = 1'b0;
    reg_we_r   = 1'b0;
    ret_r      = 1'b0;
    pc_src     = PCS_PC4;
    alu_src_b  = 1'b0;
    alu_op     = ALU_ADD;
    reg_dst    = RD_RT;
    mem_to_reg = M2R_ALU;
    CEN        = 1'b1;
    WEN        = 1'b1;
    OEN        = 1'b1;
    case (state_q)
      S_FETCH: begin
        ir_we_r = fetch_last;
        pc_we_r = fetch_last;
      end
      S_EXEC: begin
        case (cls_q)
          CLS_R:    alu_op = ALU_FUNCT;
          CLS_IALU: begin alu_src_b = 1'b1; alu_op = ALU_IMM; end
          CLS_LW, CLS_SW: begin alu_src_b = 1'b1; alu_op = ALU_ADD; end
          CLS_JR:   begin pc_we_r = 1'b1; pc_src = PCS_RS; ret_r = 1'b1; end
          CLS_BEQ:  begin alu_op = ALU_SUB; pc_src = PCS_BR; pc_we_r = zero;  ret_r = 1'b1; end
          CLS_BNE:  begin alu_op = ALU_SUB; pc_src = PCS_BR; pc_we_r = !zero; ret_r = 1'b1; end
          CLS_J:    begin pc_we_r = 1'b1; pc_src = PCS_JMP; ret_r = 1'b1; end
          CLS_JAL: begin
            pc_we_r    = 1'b1;
            pc_src     = PCS_JMP;
            reg_we_r   = 1'b1;
            reg_dst    = RD_RA;
            mem_to_reg = M2R_PC4;
            ret_r      = 1'b1;
          end
          default:  ret_r = 1'b1;
        endcase
      end
      S_MEM: begin
        CEN = 1'b0;
        if (cls_q == CLS_LW) OEN = 1'b0;
        else                 WEN = 1'b0;
        ret_r = (cls_q == CLS_SW) && mem_last;
      end
      S_WB: begin
        reg_we_r = 1'b1;
        ret_r    = 1'b1;
        if (cls_q == CLS_R)  reg_dst    = RD_RD;
        if (cls_q == CLS_LW) mem_to_reg = M2R_MEM;
      end
      default: ;
    endcase
    ret_r = ret_r && strobe_en;
  end

  assign ir_we     = ir_we_r  && strobe_en;
  assign pc_we     = pc_we_r  && strobe_en;
  assign reg_we    = reg_we_r && strobe_en;
  assign retired   = ret_r;
  assign illegal   = (state_q == S_EXEC) && ill_q && strobe_en;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: per-class cycle-pattern model with
// directed scenarios plus randomized instruction/stall streams.
module tb_mips_mc_ctrl;

  localparam int L = 1;
  localparam int D = 3;
  localparam int CW = 4;

  // {ir_we,pc_we,pc_src,alu_src_b,alu_op,reg_dst,mem_to_reg,reg_we,CEN,WEN,OEN,illegal,retired}
  localparam logic [16:0] IDLE    = 17'b0_0_00_0_00_00_00_0_1_1_1_0_0;
  localparam logic [16:0] STROBES = 17'b1_1_00_0_00_00_00_1_0_0_0_1_1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic zero = 1'b0;
  logic stall = 1'b0;
  logic ir_we, pc_we, alu_src_b, reg_we, CEN, WEN, OEN, illegal, retired;
  logic [1:0] pc_src, alu_op, reg_dst, mem_to_reg;
  logic [CW-1:0] instr_cnt;
  logic [16:0] obs;

  int nvec = 0;
  int nerr = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic [16:0] exp_q[$];

  mips_mc_ctrl #(.IMEM_LAT(L), .DMEM_LAT(D), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .stall(stall),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_we(reg_we), .CEN(CEN), .WEN(WEN),
    .OEN(OEN), .illegal(illegal), .retired(retired), .instr_cnt(instr_cnt)
  );

  assign obs = {ir_we, pc_we, pc_src, alu_src_b, alu_op, reg_dst, mem_to_reg,
                reg_we, CEN, WEN, OEN, illegal, retired};

  always #5 clk = ~clk;

  function automatic logic [16:0] mk(input logic ir, pc, input logic [1:0] pcs,
                                     input logic asb, input logic [1:0] aop, rd, m2r,
                                     input logic rw, cen, wen, oen, ill, ret);
    return {ir, pc, pcs, asb, aop, rd, m2r, rw, cen, wen, oen, ill, ret};
  endfunction

  // Instruction latency straight from the class table.
  function automatic int lat(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: return (fn == 6'h08) ? L + 2 : L + 3;
      6'h08, 6'h0A, 6'h0C, 6'h0D: return L + 3;
      6'h23: return L + D + 3;
      6'h2B: return L + D + 2;
      default: return L + 2;
    endcase
  endfunction

  // Expected per-cycle output pattern for one unstalled instruction.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z);
    exp_q.delete();
    for (int i = 0; i < L - 1; i++) exp_q.push_back(IDLE);
    exp_q.push_back(mk(1,1,0,0,0,0,0,0,1,1,1,0,0));
    exp_q.push_back(IDLE);
    case (op)
      6'h00: begin
        if (fn == 6'h08) exp_q.push_back(mk(0,1,3,0,0,0,0,0,1,1,1,0,1));
        else begin
          exp_q.push_back(mk(0,0,0,0,2,0,0,0,1,1,1,0,0));
          exp_q.push_back(mk(0,0,0,0,0,1,0,1,1,1,1,0,1));
        end
      end
      6'h08, 6'h0A, 6'h0C, 6'h0D: begin
        exp_q.push_back(mk(0,0,0,1,3,0,0,0,1,1,1,0,0));
        exp_q.push_back(mk(0,0,0,0,0,0,0,1,1,1,1,0,1));
      end
      6'h23: begin
        exp_q.push_back(mk(0,0,0,1,0,0,0,0,1,1,1,0,0));
        for (int i = 0; i < D; i++) exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,1,0,0,0));
        exp_q.push_back(mk(0,0,0,0,0,0,1,1,1,1,1,0,1));
      end
      6'h2B: begin
        exp_q.push_back(mk(0,0,0,1,0,0,0,0,1,1,1,0,0));
        for (int i = 0; i < D; i++)
          exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,0, (i == D - 1) ? 1'b1 : 1'b0));
      end
      6'h04: exp_q.push_back(mk(0, z,1,0,1,0,0,0,1,1,1,0,1));
      6'h05: exp_q.push_back(mk(0,!z,1,0,1,0,0,0,1,1,1,0,1));
      6'h02: exp_q.push_back(mk(0,1,2,0,0,0,0,0,1,1,1,0,1));
      6'h03: exp_q.push_back(mk(0,1,2,0,0,2,2,1,1,1,1,0,1));
      default: exp_q.push_back(mk(0,0,0,0,0,0,0,0,1,1,1,1,1));
    endcase
  endtask

  // Drive one instruction cycle by cycle and compare against the model.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int rand_pct, input int stall_at,
                           input int stall_len, input int abort_at, output int cycles);
    logic [16:0] ex;
    int nstall;
    build(op, fn, z);
    cycles = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == abort_at) break;
      nstall = (i == stall_at) ? stall_len : 0;
      if (rand_pct > 0 && $urandom_range(99) < rand_pct) nstall += $urandom_range(3, 1);
      for (int s = 0; s <= nstall; s++) begin
        @(negedge clk);
        opcode = op; funct = fn; zero = z; stall = (s < nstall);
        #1;
        ex = stall ? (exp_q[i] & ~STROBES) : exp_q[i];
        nvec++;
        if (obs !== ex) begin
          nerr++;
          $display("FAIL %s step%0d stall=%0b outputs got=%b exp=%b", tag, i, stall, obs, ex);
        end
        nvec++;
        if (instr_cnt !== exp_cnt) begin
          nerr++;
          $display("FAIL %s step%0d instr_cnt got=%0d exp=%0d", tag, i, instr_cnt, exp_cnt);
        end
        cycles++;
        if (!stall && ex[0]) exp_cnt++;
      end
    end
    stall = 1'b0;
  endtask

  task automatic check_lat(input string tag, input int got, input int want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s latency got=%0d exp=%0d", tag, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if (obs !== IDLE) begin nerr++; $display("FAIL reset outputs got=%b exp=%b", obs, IDLE); end
    nvec++;
    if (instr_cnt !== '0) begin nerr++; $display("FAIL reset instr_cnt got=%0d exp=0", instr_cnt); end
    exp_cnt = '0;
    rst = 1'b0;
  endtask

  task automatic test_add();
    int c;
    run_instr("add", 6'h00, 6'h20, 1'b0, 0, -1, 0, -1, c);
    check_lat("add", c, lat(6'h00, 6'h20));
  endtask

  task automatic test_lw_sw();
    int c;
    run_instr("lw", 6'h23, 6'h00, 1'b0, 0, -1, 0, -1, c);
    check_lat("lw", c, L + D + 3);
    run_instr("sw", 6'h2B, 6'h00, 1'b1, 0, -1, 0, -1, c);
    check_lat("sw", c, L + D + 2);
  endtask

  task automatic test_branch();
    int c;
    run_instr("beq_z1", 6'h04, 6'h00, 1'b1, 0, -1, 0, -1, c);
    run_instr("beq_z0", 6'h04, 6'h00, 1'b0, 0, -1, 0, -1, c);
    run_instr("bne_z0", 6'h05, 6'h00, 1'b0, 0, -1, 0, -1, c);
    check_lat("bne", c, L + 2);
  endtask

  task automatic test_jal_jr();
    int c;
    run_instr("jal", 6'h03, 6'h00, 1'b0, 0, -1, 0, -1, c);
    run_instr("jr", 6'h00, 6'h08, 1'b0, 0, -1, 0, -1, c);
    check_lat("jr", c, L + 2);
  endtask

  task automatic test_stall();
    int c;
    run_instr("lw_stall", 6'h23, 6'h00, 1'b0, 0, L + 3, 4, -1, c);
    check_lat("lw_stall", c, L + D + 3 + 4);
    run_instr("add_fetch_stall", 6'h00, 6'h21, 1'b0, 0, L - 1, 2, -1, c);
    check_lat("add_fetch_stall", c, L + 3 + 2);
  endtask

  task automatic test_illegal();
    int c;
    run_instr("ill3F", 6'h3F, 6'h00, 1'b0, 0, -1, 0, -1, c);
    run_instr("ill11", 6'h11, 6'h00, 1'b1, 0, L + 1, 2, -1, c);
  endtask

  task automatic test_wrap();
    int c;
    while (exp_cnt != {CW{1'b1}}) run_instr("wrap_fill", 6'h02, 6'h00, 1'b0, 0, -1, 0, -1, c);
    run_instr("wrap_last", 6'h02, 6'h00, 1'b0, 0, -1, 0, -1, c);
    @(posedge clk); #1;
    nvec++;
    if (instr_cnt !== '0) begin nerr++; $display("FAIL wrap instr_cnt got=%0d exp=0", instr_cnt); end
  endtask

  task automatic test_rst_mid();
    int c;
    // Reset during a store: all memory strobes release on the next edge.
    run_instr("sw_abort", 6'h2B, 6'h00, 1'b0, 0, -1, 0, L + 3, c);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    nvec++;
    if (obs !== IDLE) begin nerr++; $display("FAIL rst_mid_sw outputs got=%b exp=%b", obs, IDLE); end
    nvec++;
    if (instr_cnt !== '0) begin nerr++; $display("FAIL rst_mid_sw instr_cnt got=%0d exp=0", instr_cnt); end
    rst = 1'b0;
    exp_cnt = '0;
    // Reset together with stall during a load: reset wins.
    run_instr("lw_abort", 6'h23, 6'h00, 1'b0, 0, -1, 0, L + 3, c);
    @(negedge clk); rst = 1'b1; stall = 1'b1;
    @(posedge clk); #1;
    nvec++;
    if (obs !== IDLE) begin nerr++; $display("FAIL rst_stall outputs got=%b exp=%b", obs, IDLE); end
    rst = 1'b0; stall = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_random();
    logic [5:0] ops [0:12];
    logic [5:0] op, fn;
    int c;
    ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A,
            6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h3F};
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(12)];
      if ($urandom_range(9) == 0) op = 6'($urandom_range(63));
      fn = ($urandom_range(3) == 0) ? 6'h08 : 6'($urandom_range(63));
      run_instr("random", op, fn, 1'($urandom_range(1)), 25, -1, 0, -1, c);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_sw();
    test_branch();
    test_jal_jr();
    test_stall();
    test_illegal();
    test_wrap();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
